// File: rtl/cpu_controller.sv
// cpu_controller: instruction-cycle sequencer for the 8-bit accumulator CPU.
// Steps an 8-phase fetch/execute cycle and decodes the 3-bit IR opcode into
// the memory, PC, IR and accumulator strobes. It also acts on the ALU zero
// flag for SKZ.
// Optional single-step support is compiled in with CPU_CTRL_SINGLE_STEP_EN.
// It adds step_mode/step inputs and an internal WAIT state entered after phase 7.
module cpu_controller #(
    parameter int OP_W    = 3,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    output logic [PHASE_W-1:0] phase,
    output logic               sel,
    output logic               rd,
    output logic               wr,
    output logic               ld_ir,
    output logic               ld_ac,
    output logic               ld_pc,
    output logic               inc_pc,
    output logic               data_e,
    output logic               halt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    phase_t phase_q, phase_nxt;
    logic   halted_q, halted_nxt;
    logic   in_wait;
    logic   alu_op;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic wait_q, wait_nxt;
    assign in_wait = wait_q;
`else
    assign in_wait = 1'b0;
`endif

    // In WAIT the phase register already sits at 0, but force 0 anyway so the
    // visible phase never depends on how WAIT was entered.
    assign phase  = in_wait ? '0 : PHASE_W'(phase_q);
    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register: phase counter, sticky halt flag and optional WAIT flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
            wait_q   <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_nxt;
            halted_q <= halted_nxt;
`ifdef CPU_CTRL_SINGLE_STEP_EN
            wait_q   <= wait_nxt;
`endif
        end
    end

    // Next state. HLT freezes the counter at OP_ADDR instead of advancing.
    // In step mode, phase 7 parks in WAIT until a step pulse releases it.
    always_comb begin
        phase_nxt  = phase_q;
        halted_nxt = halted_q;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        wait_nxt   = wait_q;
`endif
        if (enable && !halted_q) begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
            if (wait_q) begin
                if (step || !step_mode) begin
                    wait_nxt = 1'b0;
                end
            end else
`endif
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_nxt = 1'b1;
            end
`ifdef CPU_CTRL_SINGLE_STEP_EN
            else if (phase_q == STORE && step_mode) begin
                wait_nxt  = 1'b1;
                phase_nxt = INST_ADDR;
            end
`endif
            else begin
                phase_nxt = phase_t'(phase_q + 3'd1);
            end
        end
    end

    // Strobe decode from phase, opcode, zero and the halted/WAIT flags.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else if (in_wait) begin
            sel = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: table of per-opcode strobe patterns
// plus hand sequences for halt, enable hold, async reset and single step.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic       step_mode;
    logic       step;
`endif

    cpu_controller #(.OP_W(3), .PHASE_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .step_mode(step_mode),
        .step(step),
`endif
        .opcode(opcode),
        .zero(zero),
        .phase(phase),
        .sel(sel),
        .rd(rd),
        .wr(wr),
        .ld_ir(ld_ir),
        .ld_ac(ld_ac),
        .ld_pc(ld_pc),
        .inc_pc(inc_pc),
        .data_e(data_e),
        .halt(halt)
    );

    always #5 clk = ~clk;

    // Observed outputs, packed as {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}.
    logic [11:0] act;
    assign act = {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    // Each mask has bit p set when the strobe is high in phase p.
    typedef struct {
        logic [2:0] op;
        logic       z;
        string      name;
        logic [7:0] sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e;
    } vec_t;

    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    string       name_q[$];

    function automatic logic [11:0] pack(input logic [2:0] ph, input logic s, input logic r,
                                         input logic w, input logic ir, input logic ac,
                                         input logic pc, input logic inc, input logic de,
                                         input logic h);
        return {ph, s, r, w, ir, ac, pc, inc, de, h};
    endfunction

    task automatic drive(input logic [2:0] op, input logic z, input logic en);
        opcode = op;
        zero   = z;
        enable = en;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic z, input logic en,
                                 input logic [11:0] expv, input string name);
        drive(op, z, en);
        exp_q.push_back(expv);
        name_q.push_back(name);
    endtask

    task automatic checkOutput();
        logic [11:0] e;
        string       n;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %b, want a queued expectation", act);
            return;
        end
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s: got phase=%0d sel/rd/wr/ir/ac/pc/inc/de/halt=%b, want phase=%0d %b",
                     n, act[11:9], act[8:0], e[11:9], e[8:0]);
        end
    endtask

    task automatic pushReset(input string name);
        exp_q.push_back(pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        name_q.push_back(name);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        pushReset(name);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{op:3'd2, z:1'b0, name:"add",    sel:8'h0F, rd:8'hEE, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h80, ld_pc:8'h00, inc_pc:8'h10, data_e:8'h00};
        vecs[1] = '{op:3'd3, z:1'b1, name:"and",    sel:8'h0F, rd:8'hEE, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h80, ld_pc:8'h00, inc_pc:8'h10, data_e:8'h00};
        vecs[2] = '{op:3'd4, z:1'b0, name:"xor",    sel:8'h0F, rd:8'hEE, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h80, ld_pc:8'h00, inc_pc:8'h10, data_e:8'h00};
        vecs[3] = '{op:3'd5, z:1'b1, name:"lda",    sel:8'h0F, rd:8'hEE, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h80, ld_pc:8'h00, inc_pc:8'h10, data_e:8'h00};
        vecs[4] = '{op:3'd1, z:1'b1, name:"skz_z1", sel:8'h0F, rd:8'h0E, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h00, ld_pc:8'h00, inc_pc:8'h50, data_e:8'h00};
        vecs[5] = '{op:3'd1, z:1'b0, name:"skz_z0", sel:8'h0F, rd:8'h0E, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h00, ld_pc:8'h00, inc_pc:8'h10, data_e:8'h00};
        vecs[6] = '{op:3'd6, z:1'b0, name:"sto",    sel:8'h0F, rd:8'h0E, wr:8'h80, ld_ir:8'h0C, ld_ac:8'h00, ld_pc:8'h00, inc_pc:8'h10, data_e:8'hC0};
        vecs[7] = '{op:3'd7, z:1'b1, name:"jmp",    sel:8'h0F, rd:8'h0E, wr:8'h00, ld_ir:8'h0C, ld_ac:8'h00, ld_pc:8'hC0, inc_pc:8'h10, data_e:8'h00};

        rst    = 1'b1;
        enable = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        #2;
        pushReset("reset_initial");
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back instructions; each row also proves the 7->0 wrap.
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 8; p++) begin
                @(negedge clk);
                applyStimulus(vecs[i].op, vecs[i].z, 1'b1,
                              pack(3'(p), vecs[i].sel[p], vecs[i].rd[p], vecs[i].wr[p],
                                   vecs[i].ld_ir[p], vecs[i].ld_ac[p], vecs[i].ld_pc[p],
                                   vecs[i].inc_pc[p], vecs[i].data_e[p], 1'b0),
                              $sformatf("%s_ph%0d", vecs[i].name, p));
                checkOutput();
            end
        end

        // HLT: halt shows in phase 4, then the controller freezes there.
        doReset("reset_before_hlt");
        drive(3'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(3'd0, 1'b0, 1'b1,
                      pack(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "hlt_ph4");
        checkOutput();
        repeat (20) @(negedge clk);
        applyStimulus(3'd2, 1'b1, 1'b1,
                      pack(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "halted_frozen");
        checkOutput();
        rst = 1'b1;
        pushReset("async_reset_from_halt");
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Enable dropped in phase 6 of STO: phase and data_e must hold.
        drive(3'd6, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'd6, 1'b0, 1'b0,
                          pack(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                          $sformatf("hold_ph6_%0d", k));
            checkOutput();
            @(negedge clk);
        end
        applyStimulus(3'd6, 1'b0, 1'b1,
                      pack(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "reenable_ph6");
        checkOutput();
        @(negedge clk);
        applyStimulus(3'd6, 1'b0, 1'b1,
                      pack(3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "reenable_ph7");
        checkOutput();
        rst = 1'b1;
        pushReset("async_reset_mid_cycle");
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

`ifdef CPU_CTRL_SINGLE_STEP_EN
        // Step mode: after phase 7 the controller parks in WAIT until stepped.
        step_mode = 1'b1;
        drive(3'd2, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'd2, 1'b0, 1'b1,
                          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                          $sformatf("wait_%0d", k));
            checkOutput();
            @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        applyStimulus(3'd2, 1'b0, 1'b1,
                      pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "step_ph0");
        checkOutput();
        @(negedge clk);
        applyStimulus(3'd2, 1'b0, 1'b1,
                      pack(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "step_ph1");
        checkOutput();
        step_mode = 1'b0;
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
